sys_bus_arbiter: RTL
====================

// Module: sys_bus_arbiter
// PURPOSE
//  Shares the single sys_bus between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores).
//  Sequences each transfer: grant -> bus phase (wait bus_ack) -> one-cycle response.
//  Adds a timeout counter and drives mem_busy, which stalls IF while MEM owns or wants the bus.
//  Sits between the pipeline stages in data_path and the system bus/memory.
// PARAMETERS
//  ADDR_W      64  bus/requester address width
//  DATA_W      64  bus data width
//  TIMEOUT_CYC 16  bus-phase cycles without bus_ack before abort; 0 disables timeout
//  STARVE_MAX  4   consecutive MEM grants with if_req pending before IF is forced (ARB_STARVE_GUARD_EN only)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  if_req       in   1       IF fetch request; held with if_addr stable until if_valid
//  if_addr      in   ADDR_W  fetch address
//  if_valid     out  1       1-cycle response pulse for IF
//  if_rdata     out  32      fetched instruction = captured bus_dout[31:0]
//  if_err       out  1       IF transfer timed out (qualified by if_valid)
//  mem_req      in   1       MEM access request; held with attributes stable until mem_valid
//  mem_addr     in   ADDR_W  data address
//  mem_rd_ctrl  in   3       load type (0 = no read)
//  mem_wr_ctrl  in   3       store type (0 = no write)
//  mem_wdata    in   DATA_W  store data
//  mem_valid    out  1       1-cycle response pulse for MEM
//  mem_rdata    out  DATA_W  captured bus_dout (0 for stores)
//  mem_err      out  1       MEM transfer timed out (qualified by mem_valid)
//  mem_busy     out  1       comb: mem_req | (owner==MEM & state!=IDLE); IF stall
//  bus_req      out  1       bus phase active
//  bus_rd_ctrl  out  3       to sys_bus; BUS_RD_LW for IF, mem_rd_ctrl for MEM
//  bus_wr_ctrl  out  3       to sys_bus; 0 for IF, mem_wr_ctrl for MEM
//  bus_addr     out  ADDR_W  to sys_bus
//  bus_din      out  DATA_W  to sys_bus (store data; 0 for IF)
//  bus_dout     in   DATA_W  from sys_bus
//  bus_ack      in   1       transfer complete; bus_dout valid same cycle
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except mem_busy (comb); counters 0.
//  States:
//   IDLE     : mem_req -> MEM_BUSY; else if_req -> IF_BUSY; else stay. Grant latches owner and attributes into bus_* regs.
//   IF_BUSY/MEM_BUSY : bus_req=1, bus_* held constant.
//     bus_ack -> capture bus_dout, -> RESP.
//     tcnt==TIMEOUT_CYC-1 without ack -> RESP with err=1, rdata=0.
//   RESP     : owner's valid=1 (err if aborted); bus_req=0, bus_* = 0; -> IDLE.
//     Requester updates req/attributes at this edge.
//  Latency: request seen in IDLE at N -> bus_req at N+1 -> earliest ack N+1 -> valid N+2 -> IDLE N+3.
//   Minimum of 3 cycles per transfer; back-to-back grants every 3 cycles.
//  Simultaneous if_req & mem_req in IDLE: MEM wins (strict priority).
//  tcnt clears on grant; increments each BUSY cycle; saturates; unused when TIMEOUT_CYC=0.
//  bus_ack in IDLE/RESP is ignored. if_rdata = bus_dout[31:0], upper bits discarded.
//  Requests dropped mid-BUSY are illegal; the transfer still completes and pulses valid.
//  rst mid-transfer: abort immediately to IDLE, no valid pulse, bus_req=0 next cycle.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   scnt counts MEM grants issued while if_req=1; clears on any IF grant or when if_req=0.
//   In IDLE with scnt==STARVE_MAX and if_req=1, IF is granted over mem_req.
//   mem_busy is still asserted (IF holds its registers; fetch completes under grant).
//  Undefined: strict MEM priority; no scnt register; STARVE_MAX ignored.
// STRUCTURE
//  sys_bus_pkg (shared include): state encoding (IDLE/IF_BUSY/MEM_BUSY/RESP),
//   owner codes (OWN_IF/OWN_MEM), BUS_RD_*/BUS_WR_* ctrl constants incl. BUS_RD_LW.
//   The pipeline stages and sys_bus use the same package.
//  One sub-module: bus_timeout_timer (clear, enable, expire at TIMEOUT_CYC-1, disabled at 0).
// TESTING
//  1 if_req, if_addr=0x100, ack 2 cycles after bus_req, bus_dout=0xDEAD_BEEF_0000_0013
//    -> bus_rd_ctrl=BUS_RD_LW, if_valid pulse, if_rdata=0x00000013, if_err=0.
//  2 if_req & mem_req same cycle (store, addr 0x2000, wdata 0x55)
//    -> MEM granted first: bus_wr_ctrl=mem_wr_ctrl, bus_din=0x55; IF granted next; mem_busy=1 until RESP.
//  3 mem_req, no ack, TIMEOUT_CYC=16 -> mem_valid=1, mem_err=1, mem_rdata=0 after 16 BUSY cycles; bus_req drops.
//  4 rst asserted during MEM_BUSY -> next cycle IDLE, all outputs 0, no mem_valid; later request proceeds normally.
//  5 ack in the first BUSY cycle -> valid at N+2; continuous if_req -> grants at N, N+3, N+6.
//  6 (ARB_STARVE_GUARD_EN, STARVE_MAX=4) mem_req and if_req held high
//    -> grant order MEM,MEM,MEM,MEM,IF,MEM...; without the macro, IF is never granted.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared sys_bus encodings: arbiter states, owner codes and bus ctrl constants.
// Used by the pipeline stages, the arbiter and sys_bus.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_e;

    localparam logic [2:0] BUS_RD_NONE = 3'd0;
    localparam logic [2:0] BUS_RD_LB   = 3'd1;
    localparam logic [2:0] BUS_RD_LH   = 3'd2;
    localparam logic [2:0] BUS_RD_LW   = 3'd3;
    localparam logic [2:0] BUS_RD_LD   = 3'd4;
    localparam logic [2:0] BUS_RD_LBU  = 3'd5;
    localparam logic [2:0] BUS_RD_LHU  = 3'd6;
    localparam logic [2:0] BUS_RD_LWU  = 3'd7;

    localparam logic [2:0] BUS_WR_NONE = 3'd0;
    localparam logic [2:0] BUS_WR_SB   = 3'd1;
    localparam logic [2:0] BUS_WR_SH   = 3'd2;
    localparam logic [2:0] BUS_WR_SW   = 3'd3;
    localparam logic [2:0] BUS_WR_SD   = 3'd4;

    function automatic logic is_busy(state_e s);
        return (s == IF_BUSY) || (s == MEM_BUSY);
    endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// Bus-phase watchdog: counts enabled cycles, expires at TIMEOUT_CYC-1.
// TIMEOUT_CYC = 0 removes the counter and never expires.
module bus_timeout_timer
    import sys_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    if (TIMEOUT_CYC > 0) begin : g_tmr
        localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

        logic [CW-1:0] tcnt_q;

        // saturates at LAST so a late ack cannot wrap the count
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                tcnt_q <= '0;
            end else if (en && (tcnt_q != LAST)) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end

        assign expire = en && (tcnt_q == LAST);
    end else begin : g_off
        logic unused_tmr;
        assign unused_tmr = ^{clk, rst, clr, en};
        assign expire     = 1'b0;
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Arbitrates sys_bus between IF fetches and MEM loads/stores with timeout.
// Optional IF anti-starvation guard: define ARB_STARVE_GUARD_EN.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 16,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_rd_ctrl,
    input  logic [2:0]        mem_wr_ctrl,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              mem_busy,
    output logic              bus_req,
    output logic [2:0]        bus_rd_ctrl,
    output logic [2:0]        bus_wr_ctrl,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_din,
    input  logic [DATA_W-1:0] bus_dout,
    input  logic              bus_ack
);

    state_e            state_q;
    state_e            state_d;
    owner_e            owner_q;
    logic              grant_if;
    logic              grant_mem;
    logic              force_if;
    logic              done;
    logic              expire;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [SCNT_W-1:0] scnt_q;

    // MEM grants in a row while a fetch waits
    always_ff @(posedge clk) begin
        if (rst || !if_req || grant_if) begin
            scnt_q <= '0;
        end else if (grant_mem) begin
            scnt_q <= scnt_q + 1'b1;
        end
    end

    assign force_if = if_req && (scnt_q == SCNT_W'(STARVE_MAX));
`else
    logic unused_starve;
    assign unused_starve = (STARVE_MAX != 0);
    assign force_if      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req && !force_if) begin
                    grant_mem = 1'b1;
                    state_d   = MEM_BUSY;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (bus_ack || expire) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_IF;
            bus_req     <= 1'b0;
            bus_rd_ctrl <= BUS_RD_NONE;
            bus_wr_ctrl <= BUS_WR_NONE;
            bus_addr    <= '0;
            bus_din     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (grant_mem) begin
            owner_q     <= OWN_MEM;
            bus_req     <= 1'b1;
            bus_rd_ctrl <= mem_rd_ctrl;
            bus_wr_ctrl <= mem_wr_ctrl;
            bus_addr    <= mem_addr;
            bus_din     <= mem_wdata;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            bus_req     <= 1'b1;
            bus_rd_ctrl <= BUS_RD_LW;
            bus_wr_ctrl <= BUS_WR_NONE;
            bus_addr    <= if_addr;
            bus_din     <= '0;
        end else if (done) begin
            // stores and aborted transfers return zero data
            bus_req     <= 1'b0;
            bus_rd_ctrl <= BUS_RD_NONE;
            bus_wr_ctrl <= BUS_WR_NONE;
            bus_addr    <= '0;
            bus_din     <= '0;
            err_q       <= !bus_ack;
            rdata_q     <= (bus_ack && (bus_wr_ctrl == BUS_WR_NONE))
                           ? bus_dout : '0;
        end
    end

    bus_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant_if || grant_mem),
        .en     (is_busy(state_q)),
        .expire (expire)
    );

    assign if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
    assign mem_valid = (state_q == RESP) && (owner_q == OWN_MEM);
    assign if_err    = if_valid && err_q;
    assign mem_err   = mem_valid && err_q;
    assign if_rdata  = rdata_q[31:0];
    assign mem_rdata = rdata_q;
    assign mem_busy  = mem_req || ((owner_q == OWN_MEM) && (state_q != IDLE));

endmodule
